// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store requesters.
// Data wins by default; an aging counter forces fetch through after MAX_WAIT refusals.
`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int unsigned MAX_WAIT = 4  // legal range 1..15, must fit wait_cnt
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_IF,
        RESP_D
    } resp_sel_e;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    resp_sel_e   resp_sel_q, resp_sel_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] last_raddr_q, last_raddr_d;

    logic fetch_win;
    logic data_win;
    logic data_load;

    // Grants are suppressed while reset is held so every output sits at its reset value.
    always_comb begin
        fetch_win = rst_n && if_req && (!d_req || (wait_cnt_q == MAX_WAIT_C));
        data_win  = rst_n && d_req && !fetch_win;
        data_load = data_win && !d_we;
        if_gnt    = fetch_win;
        d_gnt     = data_win;
    end

    always_comb begin
        wait_cnt_d = 4'd0;
        if (if_req && !fetch_win) begin
            wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 4'd1;
        end
    end

    always_comb begin
        last_raddr_d = last_raddr_q;
        if (fetch_win) begin
            last_raddr_d = if_addr;
        end else if (data_load) begin
            last_raddr_d = d_addr;
        end
    end

    always_comb begin
        mem_write         = 1'b0;
        mem_funct3        = 3'b010;
        mem_write_address = 32'd0;
        mem_write_data    = 32'd0;
        mem_read_address  = last_raddr_q;
        if (fetch_win) begin
            mem_read_address = if_addr;
        end else if (data_win) begin
            mem_funct3 = d_funct3;
            if (d_we) begin
                mem_write         = 1'b1;
                mem_write_address = d_addr;
                mem_write_data    = d_wdata;
            end else begin
                mem_read_address = d_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_sel_q   <= RESP_NONE;
            wait_cnt_q   <= 4'd0;
            last_raddr_q <= 32'd0;
        end else begin
            resp_sel_q   <= resp_sel_d;
            wait_cnt_q   <= wait_cnt_d;
            last_raddr_q <= last_raddr_d;
        end
    end

    // The tag remembers who owns the read response arriving next cycle; stores get none.
    always_comb begin
        resp_sel_d = RESP_NONE;
        if (fetch_win) begin
            resp_sel_d = RESP_IF;
        end else if (data_load) begin
            resp_sel_d = RESP_D;
        end
    end

    always_comb begin
        if_rvalid = (resp_sel_q == RESP_IF);
        d_rvalid  = (resp_sel_q == RESP_D);
        if_rdata  = if_rvalid ? mem_read_data : 32'd0;
        d_rdata   = d_rvalid  ? mem_read_data : 32'd0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a one-cycle-latency memory model
// and per-requester response scoreboards.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_address;
    logic [31:0] mem_read_data;

    int assertCount = 0;
    int failCount   = 0;
    int cycleCnt    = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    resp_t ifQ[$];
    resp_t dQ[$];

    logic        expIfValid;
    logic [31:0] expIfData;
    logic        expDValid;
    logic [31:0] expDData;

    logic [31:0] memArray [0:255];

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .if_req            (if_req),
        .if_addr           (if_addr),
        .if_gnt            (if_gnt),
        .if_rvalid         (if_rvalid),
        .if_rdata          (if_rdata),
        .d_req             (d_req),
        .d_we              (d_we),
        .d_funct3          (d_funct3),
        .d_addr            (d_addr),
        .d_wdata           (d_wdata),
        .d_gnt             (d_gnt),
        .d_rvalid          (d_rvalid),
        .d_rdata           (d_rdata),
        .mem_write         (mem_write),
        .mem_funct3        (mem_funct3),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_read_address  (mem_read_address),
        .mem_read_data     (mem_read_data)
    );

    function automatic logic [31:0] initWord(input int idx);
        return 32'hC0DE_0000 | 32'(idx);
    endfunction

    // Word-wide memory: writes commit at the edge, reads return one edge later.
    always @(posedge clk) begin
        if (mem_write) memArray[mem_write_address[9:2]] <= mem_write_data;
        mem_read_data <= memArray[mem_read_address[9:2]];
    end

    always @(posedge clk) cycleCnt++;

    // Response monitor: each requester sees rvalid exactly when its oldest entry is due.
    always @(negedge clk) begin
        expIfValid = (ifQ.size() > 0) && (ifQ[0].due == cycleCnt);
        expIfData  = expIfValid ? ifQ[0].data : 32'd0;
        expDValid  = (dQ.size() > 0) && (dQ[0].due == cycleCnt);
        expDData   = expDValid ? dQ[0].data : 32'd0;
        assertCount++;
        if (if_rvalid !== expIfValid || if_rdata !== expIfData) begin
            failCount++;
            $display("[TB] FAIL if_resp cycle %0d: got rvalid=%b rdata=%h, expected rvalid=%b rdata=%h",
                     cycleCnt, if_rvalid, if_rdata, expIfValid, expIfData);
        end
        assertCount++;
        if (d_rvalid !== expDValid || d_rdata !== expDData) begin
            failCount++;
            $display("[TB] FAIL d_resp cycle %0d: got rvalid=%b rdata=%h, expected rvalid=%b rdata=%h",
                     cycleCnt, d_rvalid, d_rdata, expDValid, expDData);
        end
        if (expIfValid) void'(ifQ.pop_front());
        if (expDValid)  void'(dQ.pop_front());
    end

    task automatic pushIf(input logic [31:0] data);
        resp_t r;
        r.due  = cycleCnt + 1;
        r.data = data;
        ifQ.push_back(r);
    endtask

    task automatic pushD(input logic [31:0] data);
        resp_t r;
        r.due  = cycleCnt + 1;
        r.data = data;
        dQ.push_back(r);
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic setIdle;
        if_req   = 1'b0;
        if_addr  = 32'd0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_funct3 = 3'b010;
        d_addr   = 32'd0;
        d_wdata  = 32'd0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        setIdle();
        #12;
        assertCount++;
        if ({if_rvalid, d_rvalid, mem_write, if_gnt, d_gnt} !== 5'b0 || if_rdata !== 32'd0 ||
            d_rdata !== 32'd0 || mem_read_address !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: got rv=%b/%b gnt=%b/%b we=%b rdata=%h/%h raddr=%h, expected all zero",
                     if_rvalid, d_rvalid, if_gnt, d_gnt, mem_write, if_rdata, d_rdata, mem_read_address);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_fetch_only;
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            if_req  = 1'b1;
            if_addr = 32'(4 * k);
            settle();
            assertCount++;
            if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_write !== 1'b0 ||
                mem_read_address !== 32'(4 * k) || mem_funct3 !== 3'b010) begin
                failCount++;
                $display("[TB] FAIL fetch_only_%0d: got gnt=%b/%b we=%b raddr=%h f3=%b, expected gnt=1/0 we=0 raddr=%h f3=010",
                         k, if_gnt, d_gnt, mem_write, mem_read_address, mem_funct3, 32'(4 * k));
            end
            pushIf(initWord(k));
        end
        nextCycle();
        setIdle();
        settle();
    endtask

    task automatic test_store_load;
        nextCycle();
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        settle();
        assertCount++;
        if (d_gnt !== 1'b1 || mem_write !== 1'b1 || mem_write_address !== 32'h40 ||
            mem_write_data !== 32'hDEADBEEF || mem_funct3 !== 3'b010) begin
            failCount++;
            $display("[TB] FAIL store_issue: got gnt=%b we=%b waddr=%h wdata=%h f3=%b, expected 1 1 00000040 deadbeef 010",
                     d_gnt, mem_write, mem_write_address, mem_write_data, mem_funct3);
        end
        nextCycle();
        d_we = 1'b0; d_wdata = 32'd0;
        settle();
        assertCount++;
        if (d_gnt !== 1'b1 || mem_write !== 1'b0 || mem_read_address !== 32'h40) begin
            failCount++;
            $display("[TB] FAIL load_issue: got gnt=%b we=%b raddr=%h, expected 1 0 00000040",
                     d_gnt, mem_write, mem_read_address);
        end
        pushD(32'hDEADBEEF);
        nextCycle();
        setIdle();
        settle();
        assertCount++;
        if (mem_write !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL store_one_cycle: got mem_write=%b, expected 0", mem_write);
        end
    endtask

    task automatic test_contention;
        logic [31:0] ifA;
        logic [31:0] dA;
        logic        expIf;
        ifA = 32'h100;
        dA  = 32'h200;
        for (int k = 0; k < 2 * (MAX_WAIT + 1); k++) begin
            nextCycle();
            if_req = 1'b1; if_addr = ifA;
            d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = dA;
            settle();
            expIf = ((k % (MAX_WAIT + 1)) == MAX_WAIT);
            assertCount++;
            if (if_gnt !== expIf || d_gnt !== !expIf) begin
                failCount++;
                $display("[TB] FAIL contention_%0d: got if_gnt=%b d_gnt=%b, expected if_gnt=%b d_gnt=%b",
                         k, if_gnt, d_gnt, expIf, !expIf);
            end
            if (expIf) begin
                pushIf(initWord(int'(ifA[9:2])));
                ifA = ifA + 32'd4;
            end else begin
                pushD(initWord(int'(dA[9:2])));
                dA = dA + 32'd4;
            end
        end
        nextCycle();
        setIdle();
        settle();
    endtask

    task automatic test_store_fetch;
        nextCycle();
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h44; d_wdata = 32'h12345678;
        settle();
        assertCount++;
        if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_write !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL store_vs_fetch: got if_gnt=%b d_gnt=%b we=%b, expected 0 1 1",
                     if_gnt, d_gnt, mem_write);
        end
        nextCycle();
        d_req = 1'b0; d_we = 1'b0;
        settle();
        assertCount++;
        if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_read_address !== 32'h10) begin
            failCount++;
            $display("[TB] FAIL fetch_after_store: got if_gnt=%b d_gnt=%b raddr=%h, expected 1 0 00000010",
                     if_gnt, d_gnt, mem_read_address);
        end
        pushIf(initWord(4));
        nextCycle();
        setIdle();
        settle();
    endtask

    task automatic test_reset_mid_op;
        // Part A: fetch response in flight is dropped by reset.
        nextCycle();
        if_req = 1'b1; if_addr = 32'h20;
        settle();
        assertCount++;
        if (if_gnt !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL midreset_fetch_gnt: got %b, expected 1", if_gnt);
        end
        #2;
        rst_n = 1'b0;
        setIdle();
        ifQ.delete();
        dQ.delete();
        #1;
        assertCount++;
        if ({if_rvalid, d_rvalid, mem_write, if_gnt, d_gnt} !== 5'b0 || if_rdata !== 32'd0 ||
            d_rdata !== 32'd0 || mem_read_address !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL midreset_outputs: got rv=%b/%b gnt=%b/%b we=%b raddr=%h, expected all zero",
                     if_rvalid, d_rvalid, if_gnt, d_gnt, mem_write, mem_read_address);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Part B: build up wait_cnt, reset mid-load, then confirm aging restarts from zero.
        for (int k = 0; k < MAX_WAIT; k++) begin
            nextCycle();
            if_req = 1'b1; if_addr = 32'h24;
            d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'(32'h300 + 4 * k);
            settle();
            assertCount++;
            if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL midreset_build_%0d: got if_gnt=%b d_gnt=%b, expected 0 1", k, if_gnt, d_gnt);
            end
            pushD(initWord(8'hC0 + k));
        end
        #2;
        rst_n = 1'b0;
        setIdle();
        ifQ.delete();
        dQ.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k <= MAX_WAIT; k++) begin
            nextCycle();
            if_req = 1'b1; if_addr = 32'h28;
            d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'(32'h380 + 4 * k);
            settle();
            assertCount++;
            if (if_gnt !== (k == MAX_WAIT) || d_gnt !== (k != MAX_WAIT)) begin
                failCount++;
                $display("[TB] FAIL postreset_aging_%0d: got if_gnt=%b d_gnt=%b, expected %b %b",
                         k, if_gnt, d_gnt, (k == MAX_WAIT), (k != MAX_WAIT));
            end
            if (k == MAX_WAIT) pushIf(initWord(10));
            else               pushD(initWord(8'hE0 + k));
        end
        nextCycle();
        setIdle();
        settle();
    endtask

    task automatic test_idle_hold;
        nextCycle();
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b100; d_addr = 32'h80;
        settle();
        assertCount++;
        if (d_gnt !== 1'b1 || mem_read_address !== 32'h80 || mem_funct3 !== 3'b100) begin
            failCount++;
            $display("[TB] FAIL idle_load_issue: got gnt=%b raddr=%h f3=%b, expected 1 00000080 100",
                     d_gnt, mem_read_address, mem_funct3);
        end
        pushD(initWord(32));
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            setIdle();
            settle();
            assertCount++;
            if (mem_read_address !== 32'h80 || mem_write !== 1'b0 || mem_funct3 !== 3'b010 ||
                mem_write_address !== 32'd0 || mem_write_data !== 32'd0 || if_gnt !== 1'b0 || d_gnt !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL idle_hold_%0d: got raddr=%h we=%b f3=%b waddr=%h wdata=%h gnt=%b/%b, expected 00000080 0 010 0 0 0/0",
                         k, mem_read_address, mem_write, mem_funct3, mem_write_address, mem_write_data, if_gnt, d_gnt);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) memArray[i] = initWord(i);
        test_reset();
        test_fetch_only();
        test_store_load();
        test_contention();
        test_store_fetch();
        test_reset_mid_op();
        test_idle_hold();
        nextCycle();
        settle();
        assertCount++;
        if (ifQ.size() != 0 || dQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL leftover_responses: got %0d/%0d pending, expected 0/0", ifQ.size(), dQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
